// File: rtl/tx_d_wrapper.sv
// UART 8N1 transmit front end: serialises general bytes and ADC FIFO bytes onto SDO,
// LSB first, general bytes taking priority at every frame boundary.
module tx_d_wrapper #(
    parameter int CLKS_PER_BIT  = 868,
    parameter int VALID_TIMEOUT = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] ADCData,
    input  logic [7:0] generalData,
    input  logic       generalDataWrite,
    input  logic       adcDataStreamingMode,
    input  logic       adcDataValid,
    output logic       adcDataStrobe,
    output logic       SDO
);

    localparam int BW = $clog2(CLKS_PER_BIT + 1);
    localparam int TW = $clog2(VALID_TIMEOUT + 1);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] WAIT_MAX = TW'(VALID_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_VALID,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    state_t        stateNext;
    logic [BW-1:0] baudCnt;
    logic [2:0]    bitCnt;
    logic [TW-1:0] waitCnt;
    logic [7:0]    shiftReg;
    logic [7:0]    genHold;
    logic          genPending;
    logic          genInFlight;
    logic          baudEnd;
    logic          loadGen;
    logic          loadAdc;
    logic          frameEnd;
    logic          genAccept;
    logic          sdoNext;

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode, load controls and the value SDO takes on the next edge
    always_comb begin
        stateNext = state;
        loadGen   = 1'b0;
        loadAdc   = 1'b0;
        frameEnd  = 1'b0;
        baudEnd   = (baudCnt == BAUD_MAX);
        sdoNext   = 1'b1;
        case (state)
            IDLE: begin
                if (genPending) begin
                    loadGen   = 1'b1;
                    stateNext = START;
                end else if (adcDataStreamingMode) begin
                    stateNext = REQ;
                end
            end
            REQ: stateNext = WAIT_VALID;
            WAIT_VALID: begin
                if (adcDataValid) begin
                    loadAdc   = 1'b1;
                    stateNext = START;
                end else if (waitCnt == WAIT_MAX) begin
                    stateNext = IDLE;
                end
            end
            START: begin
                sdoNext = 1'b0;
                if (baudEnd) stateNext = DATA;
            end
            DATA: begin
                sdoNext = shiftReg[0];
                if (baudEnd && bitCnt == 3'd7) stateNext = STOP;
            end
            STOP: begin
                if (baudEnd) begin
                    frameEnd  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
        // A general byte still on the line blocks new writes, except on the
        // cycle its stop bit finishes.
        genAccept = generalDataWrite && !genPending && (!genInFlight || frameEnd);
    end

    // FIFO read request is a pure decode of the one-cycle REQ state
    always_comb begin
        adcDataStrobe = (state == REQ);
    end

    // Datapath: holding register, shifter, baud/bit/timeout counters, registered SDO
    always_ff @(posedge Clock) begin
        if (Reset) begin
            SDO         <= 1'b1;
            genHold     <= '0;
            genPending  <= 1'b0;
            genInFlight <= 1'b0;
            shiftReg    <= '0;
            baudCnt     <= '0;
            bitCnt      <= '0;
            waitCnt     <= '0;
        end else begin
            SDO <= sdoNext;

            if (genAccept) begin
                genHold    <= generalData;
                genPending <= 1'b1;
            end else if (loadGen) begin
                genPending <= 1'b0;
            end

            if (loadGen) begin
                shiftReg    <= genHold;
                genInFlight <= 1'b1;
            end else if (loadAdc) begin
                shiftReg <= ADCData;
            end else if (state == DATA && baudEnd) begin
                shiftReg <= shiftReg >> 1;
            end

            if (frameEnd) genInFlight <= 1'b0;

            if (state == WAIT_VALID) begin
                waitCnt <= waitCnt + 1'b1;
            end else begin
                waitCnt <= '0;
            end

            if (state == START || state == DATA || state == STOP) begin
                baudCnt <= baudEnd ? '0 : baudCnt + 1'b1;
            end else begin
                baudCnt <= '0;
            end

            if (state == DATA) begin
                if (baudEnd) bitCnt <= bitCnt + 1'b1;
            end else begin
                bitCnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tx_d_wrapper.sv
// Bench for tx_d_wrapper: expected bytes go into a scoreboard queue, a UART
// receiver monitor decodes SDO frames and compares them against it.
module tb_tx_d_wrapper;

    localparam int CPB = 4;
    localparam int TO  = 8;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] ADCData = '0;
    logic [7:0] generalData = '0;
    logic       generalDataWrite = 1'b0;
    logic       adcDataStreamingMode = 1'b0;
    logic       adcDataValid = 1'b0;
    logic       adcDataStrobe;
    logic       SDO;

    tx_d_wrapper #(.CLKS_PER_BIT(CPB), .VALID_TIMEOUT(TO)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .ADCData(ADCData),
        .generalData(generalData),
        .generalDataWrite(generalDataWrite),
        .adcDataStreamingMode(adcDataStreamingMode),
        .adcDataValid(adcDataValid),
        .adcDataStrobe(adcDataStrobe),
        .SDO(SDO)
    );

    always #5 Clock = ~Clock;

    int   checks = 0;
    int   passes = 0;
    logic [7:0] expQ[$];
    logic [7:0] fifoQ[$];
    logic monEnable = 1'b0;
    logic rxBusy = 1'b0;
    logic forceStream = 1'b0;
    int   strobeCount = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endfunction

    // UART receiver monitor: samples mid-bit, compares each frame with the scoreboard
    initial begin
        logic [9:0] bits;
        logic [7:0] exp;
        forever begin
            @(negedge Clock);
            if (monEnable && !Reset && SDO === 1'b0) begin
                rxBusy = 1'b1;
                @(negedge Clock);
                bits[0] = SDO;
                for (int i = 1; i < 10; i++) begin
                    repeat (CPB) @(negedge Clock);
                    bits[i] = SDO;
                end
                rxBusy = 1'b0;
                if (expQ.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected frame: got %0h, expected no frame", bits);
                end else begin
                    exp = expQ.pop_front();
                    check("frame", 32'(bits), 32'({1'b1, exp, 1'b0}));
                end
            end
        end
    end

    // Strobe monitor: one-cycle pulses only, never while a frame is on the line
    initial begin
        logic prevStrobe = 1'b0;
        forever begin
            @(negedge Clock);
            if (!Reset && adcDataStrobe === 1'b1) begin
                strobeCount++;
                check("strobe during frame", 32'(rxBusy), 32'd0);
                check("strobe width", 32'(prevStrobe), 32'd0);
            end
            prevStrobe = adcDataStrobe;
        end
    end

    // FIFO model: answers each strobe two cycles later with valid and the next byte
    initial begin
        int respCnt = 0;
        logic [7:0] held = '0;
        forever begin
            @(negedge Clock);
            adcDataValid = 1'b0;
            if (respCnt > 0) begin
                respCnt--;
                if (respCnt == 0) begin
                    adcDataValid = 1'b1;
                    ADCData = held;
                end
            end
            if (adcDataStrobe === 1'b1 && fifoQ.size() > 0) begin
                held = fifoQ.pop_front();
                respCnt = 2;
            end
            adcDataStreamingMode = forceStream || (fifoQ.size() != 0);
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic writeGen(input logic [7:0] d);
        @(negedge Clock);
        generalData = d;
        generalDataWrite = 1'b1;
        @(negedge Clock);
        generalDataWrite = 1'b0;
    endtask

    task automatic waitDrain(input int limit);
        int n = 0;
        while ((expQ.size() != 0 || rxBusy) && n < limit) begin
            @(negedge Clock);
            n++;
        end
        check("drain timeout", 32'(n < limit), 32'd1);
    endtask

    initial begin
        int n;
        int gap;
        logic sawLow;

        // Reset held for three cycles
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            check("reset SDO", 32'(SDO), 32'd1);
            check("reset strobe", 32'(adcDataStrobe), 32'd0);
        end
        Reset = 1'b0;
        @(negedge Clock);
        check("post-reset SDO", 32'(SDO), 32'd1);
        check("post-reset strobe", 32'(adcDataStrobe), 32'd0);
        monEnable = 1'b1;

        // General byte 0x32, start bit two edges after the write edge
        expQ.push_back(8'h32);
        writeGen(8'h32);
        check("latency N", 32'(SDO), 32'd1);
        @(negedge Clock);
        check("latency N+1", 32'(SDO), 32'd1);
        @(negedge Clock);
        check("latency N+2 start", 32'(SDO), 32'd0);
        waitDrain(200);

        // ADC stream of three bytes
        strobeCount = 0;
        @(negedge Clock);
        fifoQ = '{8'hAA, 8'hCC, 8'hF0};
        expQ.push_back(8'hAA);
        expQ.push_back(8'hCC);
        expQ.push_back(8'hF0);
        repeat (2) @(negedge Clock);
        waitDrain(1000);
        repeat (20) @(negedge Clock);
        check("stream strobe count", 32'(strobeCount), 32'd3);

        // General write during an ADC frame goes out before the next ADC byte
        @(negedge Clock);
        fifoQ = '{8'hA1, 8'h3C};
        expQ.push_back(8'hA1);
        expQ.push_back(8'h55);
        expQ.push_back(8'h3C);
        n = 0;
        while (!rxBusy && n < 100) begin
            @(negedge Clock);
            n++;
        end
        check("priority frame seen", 32'(n < 100), 32'd1);
        repeat (10) @(negedge Clock);
        writeGen(8'h55);
        waitDrain(1000);

        // Timeout: strobes with no valid repeat every TO+2 cycles, line stays idle
        @(negedge Clock);
        forceStream = 1'b1;
        n = 0;
        while (adcDataStrobe !== 1'b1 && n < 50) begin
            @(negedge Clock);
            n++;
        end
        check("timeout first strobe", 32'(n < 50), 32'd1);
        gap = 0;
        sawLow = 1'b0;
        do begin
            @(negedge Clock);
            gap++;
            if (SDO !== 1'b1) sawLow = 1'b1;
        end while (adcDataStrobe !== 1'b1 && gap < 40);
        check("timeout strobe gap", 32'(gap), 32'(TO + 2));
        check("timeout SDO idle", 32'(sawLow), 32'd0);
        forceStream = 1'b0;
        repeat (20) @(negedge Clock);

        // Dropped writes: while pending and while the byte is being shifted
        expQ.push_back(8'h11);
        @(negedge Clock);
        generalData = 8'h11;
        generalDataWrite = 1'b1;
        @(negedge Clock);
        generalData = 8'h22;
        @(negedge Clock);
        generalDataWrite = 1'b0;
        repeat (10) @(negedge Clock);
        writeGen(8'h33);
        waitDrain(200);
        repeat (100) @(negedge Clock);
        waitDrain(200);

        // Reset mid-DATA aborts the frame for good
        monEnable = 1'b0;
        writeGen(8'h00);
        repeat (9) @(negedge Clock);
        check("abort mid-data bit", 32'(SDO), 32'd0);
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            check("abort reset SDO", 32'(SDO), 32'd1);
        end
        Reset = 1'b0;
        sawLow = 1'b0;
        repeat (60) begin
            @(negedge Clock);
            if (SDO !== 1'b1) sawLow = 1'b1;
        end
        check("no frame resumes", 32'(sawLow), 32'd0);
        check("scoreboard empty", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
